minsec_stop_counter: RTL and testbench
======================================

MINSEC_STOP_COUNTER -- requirements
Module: minsec_stop_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100_000_000, giving clk cycles per counted second.
REQ-002 The block SHALL have parameter MIN_MAX, default 99, giving the highest minute value before wrap.
REQ-003 Port clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port btn_run  input  1  single-cycle pulse that starts or pauses counting.
REQ-006 Port btn_clear  input  1  single-cycle pulse that stops counting and zeroes the count.
REQ-007 Port btn_lap  input  1  single-cycle pulse for lap freeze (see Configuration).
REQ-008 Port disp_data  output  14  display value min*100+sec, range 0..9959, feeding the 4-digit FND controller input_data.
REQ-009 Port anim_mode  output  1  high while IDLE, feeding the FND controller anim_mode.
REQ-010 Port running  output  1  high while in RUN.
REQ-011 Port lap_active  output  1  high while the lap freeze is held.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and PAUSE.
REQ-013 Transitions SHALL be:
- IDLE + btn_run -> RUN
- RUN + btn_run -> PAUSE
- PAUSE + btn_run -> RUN
- RUN or PAUSE + btn_clear -> IDLE
- btn_clear in IDLE has no effect.
REQ-014 When btn_run and btn_clear are high in the same cycle, btn_clear SHALL win.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only in RUN and emit a one-cycle tick at TICK_DIV-1, then wrap to 0.
REQ-016 The prescaler SHALL hold its value in PAUSE, so a paused partial second resumes and is not lost.
REQ-017 The prescaler SHALL be zeroed on entry to IDLE.
REQ-018 Counters SHALL be sec (6 bit, 0..59) and min (7 bit, 0..MIN_MAX), both zeroed on entry to IDLE.
REQ-019 On tick, sec SHALL increment; at sec=59 it SHALL wrap to 0 and min SHALL increment.
REQ-020 At MIN_MAX:59 the next tick SHALL wrap both counters to 00:00 and remain in RUN.
REQ-021 disp_data SHALL be registered and equal min*100+sec of the counter values one clk cycle earlier (latency 1).
REQ-022 anim_mode SHALL be registered and high exactly when the state of the previous cycle was IDLE.
REQ-023 running SHALL be a direct decode of state==RUN with no latency.
REQ-024 Leaving IDLE SHALL start counting from 00:00, and the first tick SHALL occur TICK_DIV cycles after the RUN-entry edge.

Reset
REQ-025 reset SHALL, on the next clk edge, force state=IDLE, prescaler=0, sec=0, min=0, lap hold cleared.
REQ-026 After reset, disp_data SHALL be 0, anim_mode=1, running=0 and lap_active=0.
REQ-027 reset SHALL override all button inputs in the same cycle, including when asserted mid-count.

Configuration
REQ-028 With macro MINSEC_STOP_LAP_EN defined, btn_lap in RUN SHALL toggle lap_active.
REQ-029 With MINSEC_STOP_LAP_EN defined, while lap_active=1 disp_data SHALL hold its value while the counters continue.
REQ-030 With MINSEC_STOP_LAP_EN defined, lap_active SHALL clear when btn_lap is pressed again, on entry to PAUSE or IDLE, and on reset.
REQ-031 With MINSEC_STOP_LAP_EN defined, btn_lap SHALL be ignored in IDLE and PAUSE.
REQ-032 Without MINSEC_STOP_LAP_EN, the btn_lap port SHALL remain present but be ignored, and lap_active SHALL be tied to 0.

Structure
REQ-033 Package minsec_stop_pkg SHALL hold the state enum (IDLE/RUN/PAUSE), SEC_MAX=59, the MIN_MAX default and the TICK_DIV default.
REQ-034 Sub-module minsec_stop_tick_gen SHALL implement the prescaler with inputs en and clr, output tick, and parameter TICK_DIV.

Verification (TICK_DIV=4 in simulation)
REQ-035 reset high 2 cycles -> disp_data=0, anim_mode=1, running=0; then btn_run pulse -> running=1 next cycle, anim_mode=0 one cycle later.
REQ-036 RUN for 60 ticks -> disp_data=100; RUN for 125 ticks total -> disp_data=205.
REQ-037 btn_run at prescaler=2 (PAUSE), wait 50 cycles, btn_run (RUN) -> next tick arrives 2 cycles after resume and disp_data unchanged during pause.
REQ-038 Preload 99:59 with MIN_MAX=99, one tick -> disp_data=0 and running=1; btn_run+btn_clear in the same cycle -> IDLE, anim_mode=1, disp_data=0.
REQ-039 With MINSEC_STOP_LAP_EN: at disp_data=7 press btn_lap, run 5 ticks -> disp_data=7, lap_active=1; press btn_lap -> disp_data=12 after 1-cycle latency.
REQ-040 reset asserted mid-count at 03:21 -> next edge state IDLE, disp_data=0 the following cycle, and btn_run in the reset cycle is ignored.

Source files
------------

// File: rtl/minsec_stop_pkg.sv
// Shared types and constants for the minute/second stopwatch.
// Holds the FSM state encoding, counter limits and display packing helper.
package minsec_stop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int SEC_MAX      = 59;
  localparam int MIN_MAX_DEF  = 99;
  localparam int TICK_DIV_DEF = 100_000_000;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 7;
  localparam int DISP_W = 14;

  // Packs min:sec into the decimal form the 4-digit FND controller expects.
  function automatic logic [DISP_W-1:0] to_disp(input logic [MIN_W-1:0] min_v,
                                                input logic [SEC_W-1:0] sec_v);
    logic [DISP_W-1:0] m_ext;
    logic [DISP_W-1:0] s_ext;
    m_ext = DISP_W'(min_v);
    s_ext = DISP_W'(sec_v);
    return (m_ext * DISP_W'(100)) + s_ext;
  endfunction

endpackage

// File: rtl/minsec_stop_tick_gen.sv
// Seconds prescaler: counts 0..TICK_DIV-1 while en is high and pulses tick
// in the last count. Holds its value while en is low; clr zeroes it.
module minsec_stop_tick_gen
  import minsec_stop_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // clr outranks en so a clear in the same cycle as a tick still zeroes.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/minsec_stop_counter.sv
// Minute/second stopwatch with IDLE/RUN/PAUSE control and registered display.
// Optional lap freeze is built when MINSEC_STOP_LAP_EN is defined.
module minsec_stop_counter
  import minsec_stop_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int MIN_MAX  = MIN_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_run,
  input  logic              btn_clear,
  input  logic              btn_lap,
  output logic [DISP_W-1:0] disp_data,
  output logic              anim_mode,
  output logic              running,
  output logic              lap_active
);

  state_t state_q;
  state_t state_d;

  logic             tick;
  logic             cnt_clr;
  logic [SEC_W-1:0] sec_q;
  logic [MIN_W-1:0] min_q;
  logic             lap_q;
  logic [DISP_W-1:0] disp_q;
  logic             anim_q;

  // btn_clear is checked first in every state so it wins over btn_run.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (btn_run && !btn_clear) state_d = RUN;
      end
      RUN: begin
        if (btn_clear)    state_d = IDLE;
        else if (btn_run) state_d = PAUSE;
      end
      PAUSE: begin
        if (btn_clear)    state_d = IDLE;
        else if (btn_run) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign cnt_clr = (state_d == IDLE);

  minsec_stop_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == RUN),
    .clr   (cnt_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      sec_q <= '0;
      min_q <= '0;
    end else if (tick) begin
      if (sec_q == SEC_W'(SEC_MAX)) begin
        sec_q <= '0;
        if (min_q == MIN_W'(MIN_MAX)) min_q <= '0;
        else                          min_q <= min_q + MIN_W'(1);
      end else begin
        sec_q <= sec_q + SEC_W'(1);
      end
    end
  end

`ifdef MINSEC_STOP_LAP_EN
  // Leaving RUN drops the freeze; presses only count while already in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q <= 1'b0;
    end else if (state_d != RUN) begin
      lap_q <= 1'b0;
    end else if ((state_q == RUN) && btn_lap) begin
      lap_q <= ~lap_q;
    end
  end
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign lap_q          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q <= '0;
    end else if (!lap_q) begin
      disp_q <= to_disp(min_q, sec_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) anim_q <= 1'b1;
    else       anim_q <= (state_q == IDLE);
  end

  assign disp_data  = disp_q;
  assign anim_mode  = anim_q;
  assign running    = (state_q == RUN);
  assign lap_active = lap_q;

endmodule

// File: tb/tb_minsec_stop_counter.sv
// Bench for minsec_stop_counter with a fast prescaler (TICK_DIV=4).
// Expected display values come from an elapsed-tick model of the stopwatch.
module tb_minsec_stop_counter;

  localparam int TICK_DIV = 4;
  localparam int MIN_MAX  = 99;
  localparam int W        = 14;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_run = 1'b0;
  logic         btn_clear = 1'b0;
  logic         btn_lap = 1'b0;
  logic [W-1:0] disp_data;
  logic         anim_mode;
  logic         running;
  logic         lap_active;

  minsec_stop_counter #(
    .TICK_DIV (TICK_DIV),
    .MIN_MAX  (MIN_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_run    (btn_run),
    .btn_clear  (btn_clear),
    .btn_lap    (btn_lap),
    .disp_data  (disp_data),
    .anim_mode  (anim_mode),
    .running    (running),
    .lap_active (lap_active)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int e0 = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pop_disp(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: scoreboard empty, got %0d expected a queued value", tag, disp_data);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 32'(disp_data), 32'(e));
    end
  endtask

  // Display value after n counted seconds from 00:00, wrapping after MIN_MAX:59.
  function automatic logic [W-1:0] disp_of(input int n);
    int m;
    int s;
    s = n % 60;
    m = (n / 60) % (MIN_MAX + 1);
    return W'(m * 100 + s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits until the given number of edges past the RUN-entry edge have passed.
  task automatic edge_to(input int n);
    while (edge_cnt < e0 + n) @(negedge clk);
  endtask

  task automatic pulse(input logic r, input logic c, input logic l);
    btn_run   = r;
    btn_clear = c;
    btn_lap   = l;
    @(negedge clk);
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    btn_lap   = 1'b0;
  endtask

  task automatic start_run();
    pulse(1'b1, 1'b0, 1'b0);
    e0 = edge_cnt;
  endtask

  // ---------------- stimulus ----------------
  int r_edge;

  initial begin
    reset = 1'b1;
    wait_n(2);
    check_val("rst_disp", 32'(disp_data), 0);
    check_val("rst_anim", 32'(anim_mode), 1);
    check_val("rst_running", 32'(running), 0);
    check_val("rst_lap", 32'(lap_active), 0);
    reset = 1'b0;
    wait_n(1);

    // Start, anim_mode lags the state by one cycle.
    start_run();
    check_val("run_running", 32'(running), 1);
    check_val("run_anim_lag", 32'(anim_mode), 1);
    wait_n(1);
    check_val("run_anim_low", 32'(anim_mode), 0);

    // N ticks are visible on disp_data at edge 4N+1 after RUN entry.
    exp_q.push_back(disp_of(59));
    exp_q.push_back(disp_of(60));
    exp_q.push_back(disp_of(124));
    exp_q.push_back(disp_of(125));
    edge_to(TICK_DIV * 60);       pop_disp("sec59");
    edge_to(TICK_DIV * 60 + 1);   pop_disp("min_carry_100");
    edge_to(TICK_DIV * 125);      pop_disp("tick124");
    edge_to(TICK_DIV * 125 + 1);  pop_disp("tick125_205");

    // Pause so that the prescaler holds 2.
    pulse(1'b1, 1'b0, 1'b0);
    check_val("pause_running", 32'(running), 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(disp_of(125));
    for (int i = 0; i < 5; i++) begin
      wait_n(10);
      pop_disp("pause_hold");
    end

    // Resume: held partial second means the tick lands 2 edges later.
    pulse(1'b1, 1'b0, 1'b0);
    r_edge = edge_cnt;
    check_val("resume_running", 32'(running), 1);
    exp_q.push_back(disp_of(125));
    exp_q.push_back(disp_of(126));
    while (edge_cnt < r_edge + 2) @(negedge clk);
    pop_disp("resume_pre_tick");
    while (edge_cnt < r_edge + 3) @(negedge clk);
    pop_disp("resume_tick");

    // Clear back to IDLE.
    pulse(1'b0, 1'b1, 1'b0);
    check_val("clr_running", 32'(running), 0);
    wait_n(1);
    check_val("clr_anim", 32'(anim_mode), 1);
    exp_q.push_back('0);
    pop_disp("clr_disp");
    pulse(1'b0, 1'b1, 1'b0);
    check_val("clr_idle_running", 32'(running), 0);
    check_val("clr_idle_anim", 32'(anim_mode), 1);

    // Full wrap at 99:59 -> 00:00 while staying in RUN.
    start_run();
    exp_q.push_back(disp_of(5999));
    exp_q.push_back(disp_of(6000));
    exp_q.push_back(disp_of(6001));
    edge_to(TICK_DIV * 6000);      pop_disp("wrap_9959");
    edge_to(TICK_DIV * 6000 + 1);  pop_disp("wrap_zero");
    check_val("wrap_running", 32'(running), 1);
    edge_to(TICK_DIV * 6001 + 1);  pop_disp("wrap_continue");

    // Run and clear together: clear wins.
    pulse(1'b1, 1'b1, 1'b0);
    check_val("runclr_running", 32'(running), 0);
    wait_n(1);
    check_val("runclr_anim", 32'(anim_mode), 1);
    check_val("runclr_disp", 32'(disp_data), 0);

    // Reset mid-count at 03:21 with btn_run in the same cycle.
    start_run();
    exp_q.push_back(disp_of(201));
    edge_to(TICK_DIV * 201 + 1);   pop_disp("mid_321");
    reset   = 1'b1;
    btn_run = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    btn_run = 1'b0;
    check_val("rst_mid_running", 32'(running), 0);
    check_val("rst_mid_anim", 32'(anim_mode), 1);
    wait_n(1);
    check_val("rst_mid_disp", 32'(disp_data), 0);
    check_val("rst_mid_still_idle", 32'(running), 0);

`ifdef MINSEC_STOP_LAP_EN
    start_run();
    exp_q.push_back(disp_of(7));
    edge_to(TICK_DIV * 7 + 1);     pop_disp("lap_at7");
    pulse(1'b0, 1'b0, 1'b1);
    check_val("lap_on", 32'(lap_active), 1);
    exp_q.push_back(disp_of(7));
    edge_to(TICK_DIV * 12 + 1);    pop_disp("lap_frozen");
    check_val("lap_still_on", 32'(lap_active), 1);
    pulse(1'b0, 1'b0, 1'b1);
    check_val("lap_off", 32'(lap_active), 0);
    exp_q.push_back(disp_of(7));
    exp_q.push_back(disp_of(12));
    pop_disp("lap_release_lag");
    wait_n(1);
    pop_disp("lap_release_12");
    pulse(1'b0, 1'b0, 1'b1);
    check_val("lap_on2", 32'(lap_active), 1);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("lap_clr_pause", 32'(lap_active), 0);
    pulse(1'b0, 1'b0, 1'b1);
    check_val("lap_ignored_pause", 32'(lap_active), 0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check_val("lap_ignored_idle", 32'(lap_active), 0);
`else
    start_run();
    pulse(1'b0, 1'b0, 1'b1);
    check_val("nolap_tied", 32'(lap_active), 0);
    exp_q.push_back(disp_of(7));
    edge_to(TICK_DIV * 7 + 1);     pop_disp("nolap_counts");
    pulse(1'b0, 1'b0, 1'b1);
    check_val("nolap_tied2", 32'(lap_active), 0);
    exp_q.push_back(disp_of(12));
    edge_to(TICK_DIV * 12 + 1);    pop_disp("nolap_no_freeze");
    pulse(1'b0, 1'b1, 1'b0);
`endif

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
